// File: rtl/drum_note_renderer_if.sv
// Spawn request handshake between the note sequencer and the play-field renderer.
interface drum_note_renderer_if;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic       spawn_ready;

    modport master (
        output spawn_valid,
        output spawn_lane,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_lane,
        output spawn_ready
    );
endinterface

// File: rtl/drum_note_renderer.sv
// DrumsHero play field: keeps a table of falling notes, advances it once per frame,
// grades pad strikes against the hit line and paints lanes, notes and hit line.
module drum_note_renderer #(
    parameter int LANES     = 4,
    parameter int MAX_NOTES = 8,
    parameter int LANE_X0   = 160,
    parameter int LANE_W    = 80,
    parameter int NOTE_H    = 16,
    parameter int HIT_Y     = 440,
    parameter int HIT_WIN   = 12,
    parameter int SPEED     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       p_tick,
    input  logic                       video_on,
    input  logic                       vsync,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    drum_note_renderer_if.slave        spawn_if,
    input  logic [LANES-1:0]           pad_hit,
    output logic [2:0]                 rgb,
    output logic                       hit_pulse,
    output logic                       miss_pulse,
    output logic [15:0]                score,
    output logic [7:0]                 streak
);
    localparam int IDX_W = $clog2(MAX_NOTES);
    localparam logic [10:0] WIN_LO    = 11'(HIT_Y - HIT_WIN);
    localparam logic [10:0] WIN_HI    = 11'(HIT_Y + HIT_WIN);
    localparam logic [10:0] SCREEN_H  = 11'(480);
    localparam logic [10:0] LANES_END = 11'(LANE_X0 + LANES * LANE_W);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vsync_q, vsync_d;
    logic [LANES-1:0]   pending_q, pending_d;
    logic [MAX_NOTES-1:0] valid_q, valid_d;
    logic [1:0]         lane_q [MAX_NOTES];
    logic [1:0]         lane_d [MAX_NOTES];
    logic [9:0]         y_q [MAX_NOTES];
    logic [9:0]         y_d [MAX_NOTES];
    logic               spawn_ready_q, spawn_ready_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic [15:0]        score_q, score_d;
    logic [7:0]         streak_q, streak_d;
    logic [2:0]         rgb_q, rgb_d;

    logic               frame_tick;
    logic               free_found, svc_found, match_found;
    logic [IDX_W-1:0]   free_idx, match_idx;
    logic [1:0]         svc_lane;
    logic [10:0]        upd_sum;

    logic [10:0]        px, py, nx_lo, nx_hi, ny_hi;
    logic               note_hit, border;
    logic [2:0]         note_rgb;

    assign frame_tick = vsync & ~vsync_q;

    function automatic logic in_window(input logic [9:0] y);
        logic [10:0] centre;
        centre = {1'b0, y} + 11'(NOTE_H / 2);
        return (centre >= WIN_LO) && (centre <= WIN_HI);
    endfunction

    function automatic logic [2:0] lane_colour(input logic [1:0] l);
        case (l)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b110;
        endcase
    endfunction

    // Note table, frame-update FSM, spawn acceptance and pad-hit grading.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        vsync_d      = vsync;
        pending_d    = pending_q;
        valid_d      = valid_q;
        lane_d       = lane_q;
        y_d          = y_q;
        score_d      = score_q;
        streak_d     = streak_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        free_found   = 1'b0;
        free_idx     = '0;
        svc_found    = 1'b0;
        svc_lane     = '0;
        match_found  = 1'b0;
        match_idx    = '0;
        upd_sum      = '0;

        for (int i = 0; i < MAX_NOTES; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        for (int l = 0; l < LANES; l++) begin
            if (pending_q[l] && !svc_found) begin
                svc_found = 1'b1;
                svc_lane  = 2'(l);
            end
        end

        for (int i = 0; i < MAX_NOTES; i++) begin
            if (valid_q[i] && (lane_q[i] == svc_lane) && in_window(y_q[i]) && !match_found) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
                if (spawn_if.spawn_valid && spawn_ready_q) begin
                    valid_d[free_idx] = 1'b1;
                    lane_d[free_idx]  = spawn_if.spawn_lane;
                    y_d[free_idx]     = '0;
                end
                if (svc_found) begin
                    pending_d[svc_lane] = 1'b0;
                    if (match_found) begin
                        valid_d[match_idx] = 1'b0;
                        hit_pulse_d        = 1'b1;
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                        if (streak_q != 8'hFF)   streak_d = streak_q + 8'd1;
                    end else begin
                        miss_pulse_d = 1'b1;
                        streak_d     = '0;
                    end
                end
            end
            UPDATE: begin
                upd_sum = {1'b0, y_q[idx_q]} + 11'(SPEED);
                if (valid_q[idx_q]) begin
                    if (upd_sum >= SCREEN_H) begin
                        valid_d[idx_q] = 1'b0;
                        miss_pulse_d   = 1'b1;
                        streak_d       = '0;
                    end else begin
                        y_d[idx_q] = upd_sum[9:0];
                    end
                end
                if (idx_q == IDX_W'(MAX_NOTES - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d     = pending_d | pad_hit;
        spawn_ready_d = (state_d == IDLE) && (valid_d != '1);
    end

    // Pixel colour for the next pixel; held between pixel enables.
    always_comb begin
        rgb_d    = rgb_q;
        px       = {1'b0, pixel_x};
        py       = {1'b0, pixel_y};
        note_hit = 1'b0;
        note_rgb = '0;
        border   = 1'b0;
        nx_lo    = '0;
        nx_hi    = '0;
        ny_hi    = '0;

        for (int i = 0; i < MAX_NOTES; i++) begin
            nx_lo = 11'(LANE_X0 + 4) + 11'(LANE_W) * 11'(lane_q[i]);
            nx_hi = 11'(LANE_X0 + LANE_W - 4) + 11'(LANE_W) * 11'(lane_q[i]);
            ny_hi = {1'b0, y_q[i]} + 11'(NOTE_H);
            if (valid_q[i] && !note_hit && (px >= nx_lo) && (px < nx_hi) &&
                (py >= {1'b0, y_q[i]}) && (py < ny_hi)) begin
                note_hit = 1'b1;
                note_rgb = lane_colour(lane_q[i]);
            end
        end

        for (int k = 0; k <= LANES; k++) begin
            if (px == 11'(LANE_X0 + k * LANE_W)) border = 1'b1;
        end

        if (p_tick) begin
            if (!video_on) begin
                rgb_d = 3'b000;
            end else if ((py == 11'(HIT_Y)) && (px >= 11'(LANE_X0)) && (px < LANES_END)) begin
                rgb_d = 3'b111;
            end else if (note_hit) begin
                rgb_d = note_rgb;
            end else if (border) begin
                rgb_d = 3'b011;
            end else begin
                rgb_d = 3'b000;
            end
        end
    end

    // All state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            vsync_q       <= 1'b0;
            pending_q     <= '0;
            valid_q       <= '0;
            lane_q        <= '{default: '0};
            y_q           <= '{default: '0};
            spawn_ready_q <= 1'b0;
            hit_pulse_q   <= 1'b0;
            miss_pulse_q  <= 1'b0;
            score_q       <= '0;
            streak_q      <= '0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            vsync_q       <= vsync_d;
            pending_q     <= pending_d;
            valid_q       <= valid_d;
            lane_q        <= lane_d;
            y_q           <= y_d;
            spawn_ready_q <= spawn_ready_d;
            hit_pulse_q   <= hit_pulse_d;
            miss_pulse_q  <= miss_pulse_d;
            score_q       <= score_d;
            streak_q      <= streak_d;
            rgb_q         <= rgb_d;
        end
    end

    assign spawn_if.spawn_ready = spawn_ready_q;
    assign rgb        = rgb_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign score      = score_q;
    assign streak     = streak_q;
endmodule

// File: tb/tb_drum_note_renderer.sv
// Directed bench for drum_note_renderer: hit/miss events go through a scoreboard queue,
// render and handshake outputs are compared directly.
module tb_drum_note_renderer;
    logic        clk;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic        vsync;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [3:0]  pad_hit;
    logic [2:0]  rgb;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [15:0] score;
    logic [7:0]  streak;

    typedef struct {
        logic        is_hit;
        logic [15:0] score;
        logic [7:0]  streak;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_compared;
    int   n_mismatched;

    drum_note_renderer_if dut_if();

    drum_note_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .vsync      (vsync),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .spawn_if   (dut_if),
        .pad_hit    (pad_hit),
        .rgb        (rgb),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .streak     (streak)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expect_event(input logic is_hit, input logic [15:0] s, input logic [7:0] k);
        exp_t e;
        e.is_hit = is_hit;
        e.score  = s;
        e.streak = k;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every hit/miss pulse is matched against the next queued expectation.
    always @(negedge clk) begin
        if (reset && (hit_pulse || miss_pulse)) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_event: got hit=%0b miss=%0b, expected no event", hit_pulse, miss_pulse);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("event_kind", 16'({hit_pulse, miss_pulse}), mon_e.is_hit ? 16'd2 : 16'd1);
                check_output("event_score", score, mon_e.score);
                check_output("event_streak", 16'(streak), 16'(mon_e.streak));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_frames(input int n);
        for (int f = 0; f < n; f++) begin
            vsync = 1'b1;
            tick(1);
            vsync = 1'b0;
            tick(9);
        end
    endtask

    task automatic apply_spawn(input logic [1:0] lane);
        int w;
        w = 0;
        while (!dut_if.spawn_ready && w < 50) begin
            tick(1);
            w++;
        end
        if (!dut_if.spawn_ready) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL spawn_ready_wait: got 0, expected 1 within 50 cycles");
        end
        dut_if.spawn_valid = 1'b1;
        dut_if.spawn_lane  = lane;
        tick(1);
        dut_if.spawn_valid = 1'b0;
    endtask

    task automatic apply_strike(input logic [3:0] mask);
        pad_hit = mask;
        tick(1);
        pad_hit = 4'b0000;
    endtask

    task automatic probe(input string name, input logic [9:0] x, input logic [9:0] y, input logic [2:0] expected);
        video_on = 1'b1;
        pixel_x  = x;
        pixel_y  = y;
        tick(1);
        check_output(name, 16'(rgb), 16'(expected));
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            tick(1);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL event_timeout: got %0d events outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [1:0] lanes_tbl [8];
        lanes_tbl = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
        n_compared   = 0;
        n_mismatched = 0;

        // Reset held with activity on the inputs.
        reset              = 1'b0;
        p_tick             = 1'b1;
        video_on           = 1'b1;
        vsync              = 1'b0;
        pixel_x            = 10'd250;
        pixel_y            = 10'd440;
        pad_hit            = 4'b1111;
        dut_if.spawn_valid = 1'b1;
        dut_if.spawn_lane  = 2'd2;
        tick(3);
        check_output("reset_rgb", 16'(rgb), 16'd0);
        check_output("reset_hit", 16'(hit_pulse), 16'd0);
        check_output("reset_miss", 16'(miss_pulse), 16'd0);
        check_output("reset_score", score, 16'd0);
        check_output("reset_streak", 16'(streak), 16'd0);
        check_output("reset_ready", 16'(dut_if.spawn_ready), 16'd0);
        dut_if.spawn_valid = 1'b0;
        pad_hit            = 4'b0000;
        video_on           = 1'b0;
        reset              = 1'b1;
        tick(1);
        check_output("ready_after_reset", 16'(dut_if.spawn_ready), 16'd1);

        // Lane 1 note, ten frames -> top edge at y=20.
        $display("[TB] render after ten frames");
        apply_spawn(2'd1);
        apply_frames(10);
        probe("note_lane1", 10'd250, 10'd25, 3'b010);
        probe("below_note", 10'd250, 10'd40, 3'b000);
        probe("border_k1", 10'd240, 10'd100, 3'b011);
        probe("border_k4", 10'd480, 10'd200, 3'b011);
        probe("hit_line", 10'd250, 10'd440, 3'b111);
        probe("hit_line_outside", 10'd100, 10'd440, 3'b000);
        p_tick = 1'b0;
        probe("hold_no_ptick", 10'd240, 10'd100, 3'b000);
        p_tick = 1'b1;
        video_on = 1'b0;
        pixel_x  = 10'd250;
        pixel_y  = 10'd25;
        tick(1);
        check_output("blank_video", 16'(rgb), 16'd0);

        // Lane 0 note: strike far from the line, then on it; lane 1 note on the window edge.
        $display("[TB] hit grading");
        apply_spawn(2'd0);
        apply_frames(106);
        expect_event(1'b0, 16'd0, 8'd0);
        apply_strike(4'b0001);
        wait_drain();
        apply_frames(106);
        probe("note_lane0_424", 10'd200, 10'd430, 3'b100);
        expect_event(1'b1, 16'd1, 8'd1);
        apply_strike(4'b0001);
        wait_drain();
        probe("note_lane0_gone", 10'd200, 10'd430, 3'b000);
        expect_event(1'b1, 16'd2, 8'd2);
        apply_strike(4'b0010);
        wait_drain();

        // Streak of three, then a note falls off the bottom.
        $display("[TB] screen exit");
        apply_spawn(2'd2);
        apply_spawn(2'd3);
        apply_frames(212);
        expect_event(1'b1, 16'd3, 8'd3);
        apply_strike(4'b0100);
        wait_drain();
        apply_frames(27);
        probe("note_lane3_478", 10'd420, 10'd479, 3'b110);
        expect_event(1'b0, 16'd3, 8'd0);
        apply_frames(1);
        wait_drain();
        probe("note_lane3_exited", 10'd420, 10'd479, 3'b000);

        // Strike during UPDATE, graded on the post-update position; repeat pulse absorbed.
        $display("[TB] strike during update");
        apply_spawn(2'd2);
        apply_frames(209);
        expect_event(1'b1, 16'd4, 8'd1);
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        apply_strike(4'b0100);
        tick(1);
        apply_strike(4'b0100);
        tick(8);
        wait_drain();
        tick(5);
        probe("note_lane2_gone", 10'd360, 10'd430, 3'b000);

        // Full table: no acceptance while held, one slot reopens after a hit.
        $display("[TB] full table");
        for (int i = 0; i < 8; i++) apply_spawn(lanes_tbl[i]);
        check_output("ready_full", 16'(dut_if.spawn_ready), 16'd0);
        dut_if.spawn_valid = 1'b1;
        dut_if.spawn_lane  = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_output("ready_full_held", 16'(dut_if.spawn_ready), 16'd0);
        end
        dut_if.spawn_valid = 1'b0;
        probe("no_lane3_write", 10'd420, 10'd5, 3'b000);
        apply_frames(212);
        expect_event(1'b1, 16'd5, 8'd2);
        apply_strike(4'b0001);
        check_output("ready_before_service", 16'(dut_if.spawn_ready), 16'd0);
        tick(1);
        check_output("ready_after_hit", 16'(dut_if.spawn_ready), 16'd1);
        wait_drain();
        apply_spawn(2'd3);
        probe("lane3_in_freed_slot", 10'd420, 10'd5, 3'b110);

        // Reset in the middle of an update.
        $display("[TB] reset during update");
        probe("lane0_before_reset", 10'd200, 10'd430, 3'b100);
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        tick(3);
        reset = 1'b0;
        #1;
        check_output("midreset_score", score, 16'd0);
        check_output("midreset_streak", 16'(streak), 16'd0);
        check_output("midreset_ready", 16'(dut_if.spawn_ready), 16'd0);
        check_output("midreset_rgb", 16'(rgb), 16'd0);
        tick(2);
        reset = 1'b1;
        tick(1);
        check_output("ready_after_midreset", 16'(dut_if.spawn_ready), 16'd1);
        probe("table_cleared", 10'd200, 10'd430, 3'b000);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
